// File: rtl/dmb_pkg.sv
// dmb_pkg: shared state encoding and default sizing for data_mover_bram
package dmb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DMB_DWIDTH     = 32;
    localparam int DMB_AWIDTH     = 12;
    localparam int DMB_MEM_SIZE   = 4096;
    localparam int DMB_CORE_DELAY = 5;
endpackage

// File: rtl/true_dpbram.sv
// true_dpbram: true dual-port block RAM, two independent read/write ports
//   clk                      : single clock, rising edge
//   addr_a/ce_a/we_a/d_a/q_a : port A (write when ce&we, q registered when ce)
//   addr_b/ce_b/we_b/d_b/q_b : port B (same behaviour as port A)
// q holds its last value while ce is low; a read of a word written in the
// same cycle on the same port returns the old contents.
module true_dpbram
    import dmb_pkg::*;
#(
    parameter int DWIDTH   = DMB_DWIDTH,
    parameter int AWIDTH   = DMB_AWIDTH,
    parameter int MEM_SIZE = DMB_MEM_SIZE
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic              ce_a,
    input  logic              we_a,
    input  logic [DWIDTH-1:0] d_a,
    output logic [DWIDTH-1:0] q_a,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic              ce_b,
    input  logic              we_b,
    input  logic [DWIDTH-1:0] d_b,
    output logic [DWIDTH-1:0] q_b
);
    logic [DWIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (ce_a && we_a) mem[addr_a] <= d_a;
        if (ce_b && we_b) mem[addr_b] <= d_b;
        if (ce_a) q_a <= mem[addr_a];
        if (ce_b) q_b <= mem[addr_b];
    end
endmodule

// File: rtl/data_mover_bram.sv
// data_mover_bram: copies N words from BRAM0 to BRAM1 through an identity core
//   clk, reset_n              : clock; asynchronous reset, active high
//   i_run, i_num_cnt          : start pulse (IDLE only) and word count
//   o_idle/o_read/o_write/o_done : status flags
//   addr_b0/ce_b0/we_b0/d_b0/q_b0 : source BRAM0 port (read only)
//   addr_b1/ce_b1/we_b1/d_b1/q_b1 : destination BRAM1 port (write only)
// Macro DMB_CORE_PIPE_EN: when defined the core is CORE_DELAY register
// stages deep; otherwise the BRAM read data is written back directly.
module data_mover_bram
    import dmb_pkg::*;
#(
    parameter int DWIDTH     = DMB_DWIDTH,
    parameter int AWIDTH     = DMB_AWIDTH,
    parameter int MEM_SIZE   = DMB_MEM_SIZE,
    parameter int CORE_DELAY = DMB_CORE_DELAY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_read,
    output logic              o_write,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr_b0,
    output logic              ce_b0,
    output logic              we_b0,
    output logic [DWIDTH-1:0] d_b0,
    input  logic [DWIDTH-1:0] q_b0,
    output logic [AWIDTH-1:0] addr_b1,
    output logic              ce_b1,
    output logic              we_b1,
    output logic [DWIDTH-1:0] d_b1,
    input  logic [DWIDTH-1:0] q_b1
);
`ifdef DMB_CORE_PIPE_EN
    localparam int STAGES = CORE_DELAY;
`else
    localparam int STAGES = 0;
`endif
    // MEM_SIZE and q_b1 only keep the port/parameter set symmetric with the BRAMs
    localparam int UNUSED_PARAMS = MEM_SIZE + CORE_DELAY;
    logic unused_q;
    assign unused_q = ^q_b1;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] num_cnt, rd_cnt, wr_cnt;
    logic              reading, rd_vld, core_v, wr_en, last_wr;
    logic [DWIDTH-1:0] core_d;

    assign reading = (state == RUN) && (rd_cnt < num_cnt);
    assign wr_en   = (state == RUN) && core_v;
    assign last_wr = wr_en && (wr_cnt == num_cnt - AWIDTH'(1));

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (i_run ? ((i_num_cnt == '0) ? DONE : RUN) : IDLE) :
                   (state == RUN)  ? (last_wr ? DONE : RUN) : IDLE;
        o_idle   = (state == IDLE);
        o_read   = reading;
        o_write  = (state == RUN);
        o_done   = (state == DONE);
        ce_b0    = reading;
        we_b0    = 1'b0;
        addr_b0  = reading ? rd_cnt : '0;
        d_b0     = '0;
        ce_b1    = wr_en;
        we_b1    = wr_en;
        addr_b1  = wr_en ? wr_cnt : '0;
        d_b1     = wr_en ? core_d : '0;
    end

    // Counters clear outside RUN so every transfer restarts from address 0.
    // rd_vld marks the cycle in which q_b0 carries the word read one cycle earlier.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            num_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_vld  <= 1'b0;
        end else begin
            if (state == IDLE && i_run) num_cnt <= i_num_cnt;
            rd_cnt <= (state == RUN) ? rd_cnt + AWIDTH'(reading) : '0;
            wr_cnt <= (state == RUN) ? wr_cnt + AWIDTH'(wr_en) : '0;
            rd_vld <= reading;
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign core_d = q_b0;
            assign core_v = rd_vld;
        end else begin : g_pipe
            logic [DWIDTH-1:0] pd [STAGES];
            logic [STAGES-1:0] pv;
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) begin
                    for (int i = 0; i < STAGES; i++) pd[i] <= '0;
                    pv <= '0;
                end else begin
                    pd[0] <= q_b0;
                    pv[0] <= rd_vld;
                    for (int i = 1; i < STAGES; i++) begin
                        pd[i] <= pd[i-1];
                        pv[i] <= pv[i-1];
                    end
                end
            end
            assign core_d = pd[STAGES-1];
            assign core_v = pv[STAGES-1];
        end
    endgenerate
endmodule

// File: tb/tb_data_mover_bram.sv
// tb_data_mover_bram: directed self-checking bench for data_mover_bram with two true_dpbram
module tb_data_mover_bram;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MS = 4096;
`ifdef DMB_CORE_PIPE_EN
    localparam int DLY = 5;
`else
    localparam int DLY = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          i_run = 1'b0;
    logic [AW-1:0] i_num_cnt = '0;
    logic          o_idle, o_read, o_write, o_done;
    logic [AW-1:0] addr_b0, addr_b1;
    logic          ce_b0, we_b0, ce_b1, we_b1;
    logic [DW-1:0] d_b0, q_b0, d_b1, q_b1;

    logic [AW-1:0] t0_addr = '0, t1_addr = '0;
    logic          t0_ce = 1'b0, t0_we = 1'b0, t1_ce = 1'b0, t1_we = 1'b0;
    logic [DW-1:0] t0_d = '0, t1_d = '0, t0_q, t1_q;

    int checks = 0, fails = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, n_done = 0, n_run = 0, ord_bad = 0, stray = 0;
    int last_rd = 0, last_wr = 0, last_done = 0;
    logic [AW-1:0] seq_w = '0;

    always #5 clk = ~clk;

    data_mover_bram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .CORE_DELAY(5)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
        .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0), .q_b0(q_b0),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d_b1(d_b1), .q_b1(q_b1)
    );

    true_dpbram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) u_bram0 (
        .clk(clk),
        .addr_a(addr_b0), .ce_a(ce_b0), .we_a(we_b0), .d_a(d_b0), .q_a(q_b0),
        .addr_b(t0_addr), .ce_b(t0_ce), .we_b(t0_we), .d_b(t0_d), .q_b(t0_q)
    );

    true_dpbram #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) u_bram1 (
        .clk(clk),
        .addr_a(addr_b1), .ce_a(ce_b1), .we_a(we_b1), .d_a(d_b1), .q_a(q_b1),
        .addr_b(t1_addr), .ce_b(t1_ce), .we_b(t1_we), .d_b(t1_d), .q_b(t1_q)
    );

    always @(negedge clk) begin
        cyc++;
        if (o_done) begin n_done++; last_done = cyc; end
        if (o_write) n_run++;
        if (ce_b0) begin n_rd++; last_rd = cyc; end
        if (ce_b1 && we_b1) begin
            n_wr++;
            last_wr = cyc;
            if (addr_b1 !== seq_w) ord_bad++;
            seq_w++;
        end
        if (o_idle) seq_w = '0;
        if (!o_write && (ce_b0 || ce_b1 || we_b1)) stray++;
        if (we_b0 || d_b0 !== '0) stray++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int n);
        tick();
        i_num_cnt = AW'(n);
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (o_done !== 1'b1 && k < budget) begin tick(); k++; end
        checks++;
        if (o_done !== 1'b1) begin
            fails++;
            $display("FAIL %s: o_done=%b after %0d cycles, required 1", name, o_done, k);
        end
    endtask

    task automatic load0(input int n, input logic [DW-1:0] x);
        for (int i = 0; i < n; i++) begin
            tick();
            t0_addr = AW'(i); t0_d = DW'(i) ^ x; t0_ce = 1'b1; t0_we = 1'b1;
        end
        tick();
        t0_ce = 1'b0; t0_we = 1'b0;
    endtask

    task automatic fill1(input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) begin
            tick();
            t1_addr = AW'(i); t1_d = v; t1_ce = 1'b1; t1_we = 1'b1;
        end
        tick();
        t1_ce = 1'b0; t1_we = 1'b0;
    endtask

    task automatic read1(input int a, output logic [DW-1:0] v);
        tick();
        t1_addr = AW'(a); t1_ce = 1'b1; t1_we = 1'b0;
        tick();
        t1_ce = 1'b0;
        v = t1_q;
    endtask

    task automatic verify1(input int n, input string name);
        int bad = 0, first = -1;
        logic [DW-1:0] got = '0;
        for (int i = 0; i <= n; i++) begin
            tick();
            if (i > 0 && t1_q !== DW'(i - 1)) begin
                if (first < 0) begin first = i - 1; got = t1_q; end
                bad++;
            end
            t1_addr = AW'(i); t1_ce = (i < n); t1_we = 1'b0;
        end
        t1_ce = 1'b0;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d bad words, first BRAM1[%0d]=%h required %h", name, bad, first, got, DW'(first));
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (o_idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b required 1", o_idle); end
        checks++; if ({o_read, o_write, o_done} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b required 000", {o_read, o_write, o_done}); end
        checks++; if ({ce_b0, we_b0, ce_b1, we_b1} !== 4'b0000) begin fails++; $display("FAIL reset_ce_we: got %b required 0000", {ce_b0, we_b0, ce_b1, we_b1}); end
        checks++; if ({addr_b0, addr_b1, d_b0, d_b1} !== '0) begin fails++; $display("FAIL reset_buses: got %h %h %h %h required 0", addr_b0, addr_b1, d_b0, d_b1); end
        reset_n = 1'b0;
        tick();
        checks++; if (o_idle !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL post_reset_idle: idle=%b done=%b required 1 0", o_idle, o_done); end
    endtask

    task automatic test_zero();
        int r = n_rd, w = n_wr, d = n_done;
        start(0);
        checks++; if (o_done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b required 1", o_done); end
        tick();
        checks++; if (o_idle !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL zero_idle: idle=%b done=%b required 1 0", o_idle, o_done); end
        checks++; if (n_rd != r || n_wr != w) begin fails++; $display("FAIL zero_access: reads=%0d writes=%0d required 0 0", n_rd - r, n_wr - w); end
        checks++; if (n_done - d != 1) begin fails++; $display("FAIL zero_pulses: got %0d required 1", n_done - d); end
    endtask

    task automatic test_single();
        int r, w;
        logic [DW-1:0] v;
        load0(1, 32'hDEADBEEF);
        fill1(1, 32'hFFFF_FFFF);
        r = n_rd; w = n_wr;
        start(1);
        wait_done(20 + DLY, "single_done");
        checks++; if (n_rd - r != 1 || n_wr - w != 1) begin fails++; $display("FAIL single_count: reads=%0d writes=%0d required 1 1", n_rd - r, n_wr - w); end
        checks++; if (last_wr - last_rd != 1 + DLY) begin fails++; $display("FAIL single_latency: got %0d required %0d", last_wr - last_rd, 1 + DLY); end
        checks++; if (last_done - last_wr != 1) begin fails++; $display("FAIL single_done_lag: got %0d required 1", last_done - last_wr); end
        read1(0, v);
        checks++; if (v !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h required deadbeef", v); end
    endtask

    task automatic test_copy_3840();
        int d, run;
        logic [DW-1:0] v;
        load0(4095, '0);
        fill1(3841, 32'hFFFF_FFFF);
        d = n_done; run = n_run;
        start(3840);
        wait_done(3840 + DLY + 8, "copy_done");
        checks++; if (n_run - run != 3841 + DLY) begin fails++; $display("FAIL copy_run_len: got %0d required %0d", n_run - run, 3841 + DLY); end
        tick();
        checks++; if (o_idle !== 1'b1 || o_done !== 1'b0) begin fails++; $display("FAIL copy_idle: idle=%b done=%b required 1 0", o_idle, o_done); end
        checks++; if (n_done - d != 1) begin fails++; $display("FAIL copy_pulses: got %0d required 1", n_done - d); end
        verify1(3840, "copy_data");
        read1(3840, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL copy_overrun: BRAM1[3840]=%h required ffffffff", v); end
    endtask

    task automatic test_ignore_run();
        int w, d, run;
        logic [DW-1:0] v;
        fill1(17, 32'hFFFF_FFFF);
        w = n_wr; d = n_done; run = n_run;
        start(16);
        tick(); tick(); tick();
        i_run = 1'b1; i_num_cnt = AW'(100);
        tick();
        i_run = 1'b0; i_num_cnt = AW'(50);
        wait_done(40 + DLY, "ignore_done");
        checks++; if (n_wr - w != 16) begin fails++; $display("FAIL ignore_writes: got %0d required 16", n_wr - w); end
        checks++; if (n_run - run != 17 + DLY) begin fails++; $display("FAIL ignore_run_len: got %0d required %0d", n_run - run, 17 + DLY); end
        tick(); tick();
        checks++; if (n_done - d != 1 || o_idle !== 1'b1) begin fails++; $display("FAIL ignore_pulses: pulses=%0d idle=%b required 1 1", n_done - d, o_idle); end
        verify1(16, "ignore_data");
        read1(16, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ignore_overrun: BRAM1[16]=%h required ffffffff", v); end
    endtask

    task automatic test_reset_mid();
        int w, k = 0, wk;
        fill1(100, 32'hFFFF_FFFF);
        w = n_wr;
        start(100);
        while (n_wr - w < 40 && k < 200) begin tick(); k++; end
        checks++; if (n_wr - w != 40) begin fails++; $display("FAIL mid_reach40: writes=%0d required 40", n_wr - w); end
        reset_n = 1'b1;
        tick();
        checks++; if (o_idle !== 1'b1 || ce_b1 !== 1'b0 || ce_b0 !== 1'b0) begin fails++; $display("FAIL mid_abort: idle=%b ce_b0=%b ce_b1=%b required 1 0 0", o_idle, ce_b0, ce_b1); end
        tick(); tick();
        reset_n = 1'b0;
        wk = n_wr;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (n_wr != wk || o_idle !== 1'b1) begin fails++; $display("FAIL mid_quiet: writes=%0d idle=%b required 0 1", n_wr - wk, o_idle); end
        w = n_wr;
        start(100);
        wait_done(100 + DLY + 8, "mid_rerun_done");
        checks++; if (n_wr - w != 100) begin fails++; $display("FAIL mid_rerun_writes: got %0d required 100", n_wr - w); end
        verify1(100, "mid_rerun_data");
    endtask

    task automatic test_back_to_back();
        int w, d, run;
        logic [DW-1:0] v;
        fill1(4096, 32'hFFFF_FFFF);
        w = n_wr; d = n_done; run = n_run;
        start(4095);
        wait_done(4095 + DLY + 8, "b2b_done_1");
        start(4095);
        wait_done(4095 + DLY + 8, "b2b_done_2");
        checks++; if (n_wr - w != 8190) begin fails++; $display("FAIL b2b_writes: got %0d required 8190", n_wr - w); end
        checks++; if (n_run - run != 2 * (4096 + DLY)) begin fails++; $display("FAIL b2b_run_len: got %0d required %0d", n_run - run, 2 * (4096 + DLY)); end
        tick();
        checks++; if (n_done - d != 2 || o_idle !== 1'b1) begin fails++; $display("FAIL b2b_pulses: pulses=%0d idle=%b required 2 1", n_done - d, o_idle); end
        verify1(4095, "b2b_data");
        read1(4095, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_top_word: BRAM1[4095]=%h required ffffffff", v); end
    endtask

    task automatic test_bus_hygiene();
        checks++; if (ord_bad != 0) begin fails++; $display("FAIL write_order: %0d out-of-order writes, required 0", ord_bad); end
        checks++; if (stray != 0) begin fails++; $display("FAIL stray_access: %0d cycles, required 0", stray); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single();
        test_copy_3840();
        test_ignore_run();
        test_reset_mid();
        test_back_to_back();
        test_bus_hygiene();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
